// File: rtl/vram_rect_fill.sv
// vram_rect_fill
// Rectangle fill engine for the tile framebuffer that the VGA scan-out reads.
// It accepts one command: a rectangle (x0, y0, w, h) in cell units and a 16-bit
// colour word. It clips the rectangle to the COLS x ROWS grid. It then writes the
// colour into every clipped cell, in row-major order, at VGA_REGION + y*COLS + x.
//
// Ports
//   clock, reset      : single clock domain, synchronous active-high reset
//   cmd_valid/ready   : command handshake; ready is high only while idle
//   cmd_x0, cmd_y0    : rectangle origin in cells
//   cmd_w, cmd_h      : rectangle size in cells
//   cmd_color         : word written to every cell
//   mem_addr/data     : write address and data (held stable while not granted)
//   mem_wren          : write request, high for the whole fill phase
//   mem_grant         : memory accepts the current write this cycle
//   busy              : high from acceptance until the done cycle inclusive
//   done              : one-cycle completion pulse
module vram_rect_fill #(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter logic [15:0] VGA_REGION = 16'h2000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_x0,
  input  logic [7:0]  cmd_y0,
  input  logic [7:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [15:0] cmd_color,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_wren,
  input  logic        mem_grant,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, CLIP, FILL, DONE} state_t;

  localparam logic [8:0]  COLS9  = 9'(COLS);
  localparam logic [8:0]  ROWS9  = 9'(ROWS);
  localparam logic [15:0] COLS16 = 16'(COLS);

  state_t state, state_next;

  logic [7:0]  x0_q, y0_q, w_q, h_q;
  logic [15:0] color_q;
  logic [7:0]  x_q, y_q;
  logic [8:0]  x_end_q, y_end_q;
  logic [15:0] row_base_q;

  logic [8:0] x_sum, y_sum, x_end_c, y_end_c;
  logic [8:0] x_inc, y_inc;
  logic       clip_empty, x_more, y_more;

  // Clip arithmetic is done 9 bits wide, so x0+w cannot wrap past 255 and
  // slip back inside the grid. The x_more/y_more terms decide where the write
  // cursor goes after each granted write.
  always_comb begin
    x_sum      = {1'b0, x0_q} + {1'b0, w_q};
    y_sum      = {1'b0, y0_q} + {1'b0, h_q};
    x_end_c    = (x_sum > COLS9) ? COLS9 : x_sum;
    y_end_c    = (y_sum > ROWS9) ? ROWS9 : y_sum;
    clip_empty = ({1'b0, x0_q} >= COLS9) || ({1'b0, y0_q} >= ROWS9) ||
                 (w_q == 8'd0) || (h_q == 8'd0);
    x_inc      = {1'b0, x_q} + 9'd1;
    y_inc      = {1'b0, y_q} + 9'd1;
    x_more     = x_inc < x_end_q;
    y_more     = y_inc < y_end_q;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. Every output is decoded from the state alone, so
  // mem_grant only steers the next state.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    mem_wren   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = CLIP;
      end
      CLIP: begin
        busy       = 1'b1;
        state_next = clip_empty ? DONE : FILL;
      end
      FILL: begin
        busy     = 1'b1;
        mem_wren = 1'b1;
        if (mem_grant && !x_more && !y_more) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch and write cursor. row_base_q holds the address of the
  // current row's cell 0. Moving to the next row adds COLS to it, so the only
  // multiply is the one done once in CLIP.
  always_ff @(posedge clock) begin
    if (reset) begin
      x0_q       <= '0;
      y0_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= VGA_REGION;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            x0_q    <= cmd_x0;
            y0_q    <= cmd_y0;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
          end
        end
        CLIP: begin
          x_q        <= x0_q;
          y_q        <= y0_q;
          x_end_q    <= x_end_c;
          y_end_q    <= y_end_c;
          row_base_q <= VGA_REGION + 16'(y0_q) * COLS16;
        end
        FILL: begin
          if (mem_grant) begin
            if (x_more) begin
              x_q <= x_q + 8'd1;
            end else if (y_more) begin
              x_q        <= x0_q;
              y_q        <= y_q + 8'd1;
              row_base_q <= row_base_q + COLS16;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = row_base_q + {8'd0, x_q};
  assign mem_data = color_q;

endmodule

// File: tb/tb_vram_rect_fill.sv
// Self-checking bench for vram_rect_fill.
// A small model pushes the expected {addr, data} of every clipped cell into a
// queue when a command is issued. A negedge monitor pops one entry per granted
// write and compares it with the write. The scenario tasks check the handshake
// timing, the done-pulse position and the reset behaviour.
module tb_vram_rect_fill;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_x0, cmd_y0, cmd_w, cmd_h;
  logic [15:0] cmd_color;
  logic [15:0] mem_addr, mem_data;
  logic        mem_wren;
  logic        mem_grant;
  logic        busy, done;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] exp_q[$];
  int          write_count = 0;
  logic [31:0] grant_pat   = '1;

  logic        stall_prev = 1'b0;
  logic [15:0] stall_addr, stall_data;

  vram_rect_fill #(.COLS(40), .ROWS(30), .VGA_REGION(16'h2000)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .mem_wren (mem_wren),
    .mem_grant(mem_grant),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every granted write must match the next expected
  // cell. A stalled write must keep the same address and data in the next cycle.
  always @(negedge clock) begin
    logic [31:0] exp;
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        tests_run++;
        if (mem_wren !== 1'b1 || mem_addr !== stall_addr || mem_data !== stall_data) begin
          tests_failed++;
          $display("[TB] FAIL stall_hold: got wren=%b addr=%h data=%h, want wren=1 addr=%h data=%h",
                   mem_wren, mem_addr, mem_data, stall_addr, stall_data);
        end
      end
      stall_prev = (mem_wren === 1'b1) && (mem_grant === 1'b0);
      stall_addr = mem_addr;
      stall_data = mem_data;
      if (mem_wren === 1'b1 && mem_grant === 1'b1) begin
        write_count++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL unexpected_write: got addr=%h data=%h, want no write", mem_addr, mem_data);
        end else begin
          exp = exp_q.pop_front();
          if ({mem_addr, mem_data} !== exp) begin
            tests_failed++;
            $display("[TB] FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                     mem_addr, mem_data, exp[31:16], exp[15:0]);
          end
        end
      end
    end
  end

  // Reference model: enumerate the clipped cells in row-major order.
  function automatic void push_expected(input int x0, input int y0, input int w,
                                        input int h, input logic [15:0] col);
    int xe, ye, a;
    logic [15:0] a16;
    xe = x0 + w; if (xe > 40) xe = 40;
    ye = y0 + h; if (ye > 30) ye = 30;
    if (x0 < 40 && y0 < 30 && w != 0 && h != 0)
      for (int yy = y0; yy < ye; yy++)
        for (int xx = x0; xx < xe; xx++) begin
          a   = 'h2000 + yy * 40 + xx;
          a16 = a[15:0];
          exp_q.push_back({a16, col});
        end
  endfunction

  // Issue one command from an idle DUT. The task starts just after a
  // posedge. Cycle k=1 is the cycle right after the accept edge. The task
  // returns the cycle that carried done, the number of cmd_ready-low cycles,
  // the number of mem_wren cycles, and the value of cmd_ready one cycle after done.
  task automatic run_cmd(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] w,
                         input logic [7:0] h, input logic [15:0] col, input int max_cyc,
                         output int done_k, output int ready_low, output int wren_n,
                         output logic ready_after);
    push_expected(int'(x0), int'(y0), int'(w), int'(h), col);
    cmd_x0 = x0; cmd_y0 = y0; cmd_w = w; cmd_h = h; cmd_color = col;
    cmd_valid = 1'b1;
    mem_grant = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    cmd_x0 = 8'($urandom); cmd_y0 = 8'($urandom);
    cmd_w  = 8'($urandom); cmd_h  = 8'($urandom); cmd_color = 16'($urandom);
    done_k = 0; ready_low = 0; wren_n = 0;
    for (int k = 1; k <= max_cyc && done_k == 0; k++) begin
      mem_grant = (k >= 2 && k - 2 < 32) ? grant_pat[k-2] : 1'b1;
      @(negedge clock);
      if (cmd_ready !== 1'b1) ready_low++;
      if (mem_wren === 1'b1) wren_n++;
      if (done === 1'b1) done_k = k;
      @(posedge clock); #1;
    end
    mem_grant = 1'b1;
    @(negedge clock);
    ready_after = cmd_ready;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; mem_grant = 1'b1;
    cmd_x0 = '0; cmd_y0 = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run += 6;
    if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b want 1", cmd_ready); end
    if (mem_wren !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wren: got %b want 0", mem_wren); end
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    if (mem_addr !== 16'h2000) begin tests_failed++; $display("[TB] FAIL reset_addr: got %h want 2000", mem_addr); end
    if (mem_data !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_data: got %h want 0000", mem_data); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  // Runs one non-empty command with grant held high and checks the fill
  // timing against N, the number of clipped cells.
  task automatic test_fill(input string name, input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] w, input logic [7:0] h, input logic [15:0] col,
                           input int n);
    int dk, rl, wn;
    logic ra;
    run_cmd(x0, y0, w, h, col, n + 50, dk, rl, wn, ra);
    tests_run += 5;
    if (dk != n + 2) begin tests_failed++; $display("[TB] FAIL %s_done_cycle: got %0d want %0d", name, dk, n + 2); end
    if (rl != n + 2) begin tests_failed++; $display("[TB] FAIL %s_ready_low: got %0d want %0d", name, rl, n + 2); end
    if (wn != n) begin tests_failed++; $display("[TB] FAIL %s_wren_cycles: got %0d want %0d", name, wn, n); end
    if (ra !== 1'b1) begin tests_failed++; $display("[TB] FAIL %s_ready_after: got %b want 1", name, ra); end
    if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL %s_missing_writes: got %0d left want 0", name, exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_empty();
    logic [7:0] tx0[5] = '{8'd5,  8'd5, 8'd40, 8'd0,  8'd200};
    logic [7:0] ty0[5] = '{8'd5,  8'd5, 8'd0,  8'd30, 8'd0};
    logic [7:0] tw [5] = '{8'd0,  8'd3, 8'd2,  8'd2,  8'd100};
    logic [7:0] th [5] = '{8'd3,  8'd0, 8'd2,  8'd2,  8'd1};
    int dk, rl, wn;
    logic ra;
    for (int i = 0; i < 5; i++) begin
      run_cmd(tx0[i], ty0[i], tw[i], th[i], 16'hA5A5, 20, dk, rl, wn, ra);
      tests_run += 4;
      if (dk != 2) begin tests_failed++; $display("[TB] FAIL empty%0d_done_cycle: got %0d want 2", i, dk); end
      if (rl != 2) begin tests_failed++; $display("[TB] FAIL empty%0d_ready_low: got %0d want 2", i, rl); end
      if (wn != 0) begin tests_failed++; $display("[TB] FAIL empty%0d_wren_cycles: got %0d want 0", i, wn); end
      if (ra !== 1'b1) begin tests_failed++; $display("[TB] FAIL empty%0d_ready_after: got %b want 1", i, ra); end
    end
  endtask

  task automatic test_grant_stall();
    int dk, rl, wn;
    logic ra;
    grant_pat = 32'hFFFF_FFE9;
    run_cmd(8'd0, 8'd0, 8'd3, 8'd1, 16'h1234, 30, dk, rl, wn, ra);
    grant_pat = '1;
    tests_run += 4;
    if (dk != 8) begin tests_failed++; $display("[TB] FAIL stall_done_cycle: got %0d want 8", dk); end
    if (wn != 6) begin tests_failed++; $display("[TB] FAIL stall_wren_cycles: got %0d want 6", wn); end
    if (rl != 8) begin tests_failed++; $display("[TB] FAIL stall_ready_low: got %0d want 8", rl); end
    if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL stall_missing_writes: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int d1 = 0, d2 = 0;
    push_expected(1, 1, 2, 1, 16'hBEEF);
    push_expected(1, 1, 2, 1, 16'hBEEF);
    cmd_x0 = 8'd1; cmd_y0 = 8'd1; cmd_w = 8'd2; cmd_h = 8'd1; cmd_color = 16'hBEEF;
    cmd_valid = 1'b1; mem_grant = 1'b1;
    @(posedge clock); #1;
    for (int k = 1; k <= 40 && d2 == 0; k++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        if (d1 == 0) d1 = k;
        else         d2 = k;
      end
      @(posedge clock); #1;
      if (d2 != 0) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    tests_run += 3;
    if (d1 != 4) begin tests_failed++; $display("[TB] FAIL b2b_first_done: got %0d want 4", d1); end
    if (d2 != 9) begin tests_failed++; $display("[TB] FAIL b2b_second_done: got %0d want 9", d2); end
    if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL b2b_missing_writes: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_fill();
    int base, got, done_seen = 0;
    int dk, rl, wn;
    logic ra;
    push_expected(0, 0, 40, 30, 16'h5555);
    cmd_x0 = 8'd0; cmd_y0 = 8'd0; cmd_w = 8'd40; cmd_h = 8'd30; cmd_color = 16'h5555;
    cmd_valid = 1'b1; mem_grant = 1'b1;
    base = write_count;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    for (int c = 0; c < 500 && (write_count - base) < 100; c++) begin
      @(posedge clock); #1;
    end
    got = write_count - base;
    reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    tests_run += 5;
    if (got != 100) begin tests_failed++; $display("[TB] FAIL rst_write_count: got %0d want 100", got); end
    if (mem_wren !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_wren: got %b want 0", mem_wren); end
    if (cmd_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rst_mid_ready: got %b want 1", cmd_ready); end
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_done: got %b want 0", done); end
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (done === 1'b1) done_seen++;
    end
    @(posedge clock); #1;
    tests_run++;
    if (done_seen != 0) begin tests_failed++; $display("[TB] FAIL rst_no_done: got %0d pulses want 0", done_seen); end
    run_cmd(8'd0, 8'd0, 8'd1, 8'd1, 16'hC0DE, 20, dk, rl, wn, ra);
    tests_run += 3;
    if (dk != 3) begin tests_failed++; $display("[TB] FAIL rst_after_done_cycle: got %0d want 3", dk); end
    if (wn != 1) begin tests_failed++; $display("[TB] FAIL rst_after_wren: got %0d want 1", wn); end
    if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL rst_after_missing: got %0d left want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_fill("full_clear", 8'd0, 8'd0, 8'd40, 8'd30, 16'h0000, 1200);
    test_fill("small_rect", 8'd3, 8'd2, 8'd4, 8'd2, 16'h0F0F, 8);
    test_fill("corner_clip", 8'd38, 8'd29, 8'd5, 8'd5, 16'h7E57, 2);
    test_fill("x_clip", 8'd36, 8'd10, 8'd250, 8'd2, 16'h3C3C, 8);
    test_empty();
    test_grant_stall();
    test_back_to_back();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
